// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage next-PC selection with EPC and a circular return-address stack.
// Optional misaligned-redirect trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h00400000,
    parameter logic [31:0] EXC_VECTOR   = 32'h80000180,
    parameter int          INSTR_BYTES  = 4,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_target,
    input  logic                       exc_valid,
    input  logic [XLEN-1:0]            exc_pc,
    input  logic                       eret,
    input  logic                       call_valid,
    input  logic                       ret_valid,
    output logic [XLEN-1:0]            pc,
    output logic [XLEN-1:0]            pc_plus,
    output logic [XLEN-1:0]            epc,
    output logic                       in_exc,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_empty,
    output logic                       misalign
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_pc, r_epc;
    logic [XLEN-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_count;
    logic            r_in_exc, r_mis;
    logic            w_mis;
    logic [PW-1:0]   w_top_idx;

`ifdef PC_ALIGN_CHECK_EN
    localparam int AW = $clog2(INSTR_BYTES);
    assign w_mis = redirect_valid && |redirect_target[AW-1:0];
`else
    assign w_mis = 1'b0;
`endif

    assign pc_plus   = r_pc + XLEN'(INSTR_BYTES);
    assign w_top_idx = r_ptr - PW'(1);
    assign pc        = r_pc;
    assign epc       = r_epc;
    assign in_exc    = r_in_exc;
    assign ras_count = r_count;
    assign ras_empty = r_count == '0;
    assign misalign  = r_mis;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= XLEN'(RESET_VECTOR);
            r_epc    <= '0;
            r_in_exc <= 1'b0;
            r_ptr    <= '0;
            r_count  <= '0;
            r_mis    <= 1'b0;
        end else begin
            r_mis <= 1'b0;
            if (exc_valid) begin
                r_pc     <= XLEN'(EXC_VECTOR);
                r_epc    <= exc_pc;
                r_in_exc <= 1'b1;
            end else if (w_mis) begin
                r_pc     <= XLEN'(EXC_VECTOR);
                r_epc    <= redirect_target;
                r_in_exc <= 1'b1;
                r_mis    <= 1'b1;
            end else if (eret) begin
                r_pc     <= r_epc;
                r_in_exc <= 1'b0;
            end else if (redirect_valid) begin
                r_pc <= redirect_target;
            end else if (!stall) begin
                if (ret_valid && r_count != '0) begin
                    r_pc <= r_ras[w_top_idx];
                    // call+ret swaps the top entry in place instead of pop-then-push
                    if (call_valid) begin
                        r_ras[w_top_idx] <= pc_plus;
                    end else begin
                        r_ptr   <= w_top_idx;
                        r_count <= r_count - CW'(1);
                    end
                end else begin
                    r_pc <= pc_plus;
                    if (call_valid) begin
                        r_ras[r_ptr] <= pc_plus;
                        r_ptr        <= r_ptr + PW'(1);
                        r_count      <= (r_count == CW'(RAS_DEPTH)) ? r_count : r_count + CW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with a queue scoreboard for pc_sequencer (default parameters).
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, exc_valid, eret, call_valid, ret_valid;
    logic [31:0] redirect_target, exc_pc;
    logic [31:0] pc, pc_plus, epc;
    logic        in_exc, ras_empty, misalign;
    logic [2:0]  ras_count;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .eret(eret),
        .call_valid(call_valid), .ret_valid(ret_valid),
        .pc(pc), .pc_plus(pc_plus), .epc(epc), .in_exc(in_exc),
        .ras_count(ras_count), .ras_empty(ras_empty), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        inx;
        logic        mis;
        logic [2:0]  cnt;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    int          compared = 0;
    int          mismatched = 0;
    int          n_step = 0;
    logic [31:0] e_epc = 32'h0;
    logic        e_inx = 1'b0;
    logic        e_mis = 1'b0;

    function automatic void chk(input string n, input int id, input logic [31:0] a, input logic [31:0] b);
        compared++;
        if (a !== b) begin
            mismatched++;
            $display("FAIL step%0d %s: got %h, expected %h", id, n, a, b);
        end
    endfunction

    task automatic step(input logic rs, input logic st, input logic rv, input logic [31:0] rt,
                        input logic ev, input logic [31:0] ep, input logic er,
                        input logic cl, input logic rr, input logic [31:0] xpc, input logic [2:0] xcnt);
        @(negedge clk);
        reset = rs; stall = st; redirect_valid = rv; redirect_target = rt;
        exc_valid = ev; exc_pc = ep; eret = er; call_valid = cl; ret_valid = rr;
        n_step++;
        q.push_back('{n_step, xpc, e_epc, e_inx, e_mis, xcnt});
        @(posedge clk);
    endtask

    task automatic idle(input logic [31:0] xpc, input logic [2:0] xcnt);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, xpc, xcnt);
    endtask

    task automatic rst_step();
        e_epc = 32'h0; e_inx = 1'b0; e_mis = 1'b0;
        step(1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h00400000, 3'd0);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            m_e = q.pop_front();
            chk("pc", m_e.id, pc, m_e.pc);
            chk("ras_count", m_e.id, 32'(ras_count), 32'(m_e.cnt));
            chk("ras_empty", m_e.id, 32'(ras_empty), 32'(m_e.cnt == 3'd0));
            chk("epc", m_e.id, epc, m_e.epc);
            chk("in_exc", m_e.id, 32'(in_exc), 32'(m_e.inx));
            chk("misalign", m_e.id, 32'(misalign), 32'(m_e.mis));
            chk("pc_plus", m_e.id, pc_plus, m_e.pc + 32'd4);
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        exc_valid = 1'b0; exc_pc = 32'h0; eret = 1'b0; call_valid = 1'b0; ret_valid = 1'b0;
        rst_step();
        idle(32'h00400004, 0);
        idle(32'h00400008, 0);
        idle(32'h0040000C, 0);
        // stall with call: hold, no push
        rst_step();
        idle(32'h00400004, 0);
        idle(32'h00400008, 0);
        step(0, 1, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h00400008, 0);
        step(0, 1, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h00400008, 0);
        // call, redirect, ret, ret on empty
        rst_step();
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h00400004, 1);
        step(0, 0, 1, 32'h00401000, 0, 32'h0, 0, 0, 0, 32'h00401000, 1);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h00400004, 0);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h00400008, 0);
        step(0, 0, 1, 32'h00401000, 0, 32'h0, 0, 1, 0, 32'h00401000, 0);
        // five calls on a depth-4 RAS, then five rets
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h00401004, 1);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h00401008, 2);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h0040100C, 3);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h00401010, 4);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h00401014, 4);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h00401014, 3);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h00401010, 2);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h0040100C, 1);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h00401008, 0);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h0040100C, 0);
        // simultaneous call+ret, non-empty then empty
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h00401010, 1);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h00401010, 1);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h00401014, 0);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h00401018, 1);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h00401018, 0);
        // exception beats redirect/call/ret; eret twice
        e_epc = 32'h00400010; e_inx = 1'b1;
        step(0, 0, 1, 32'h00401000, 1, 32'h00400010, 0, 1, 1, 32'h80000180, 0);
        e_inx = 1'b0;
        step(0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h00400010, 0);
        step(0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h00400010, 0);
        idle(32'h00400014, 0);
        // silent wrap
        step(0, 0, 1, 32'hFFFFFFFC, 0, 32'h0, 0, 0, 0, 32'hFFFFFFFC, 0);
        idle(32'h00000000, 0);
`ifdef PC_ALIGN_CHECK_EN
        e_epc = 32'h00400002; e_inx = 1'b1; e_mis = 1'b1;
        step(0, 0, 1, 32'h00400002, 0, 32'h0, 0, 0, 0, 32'h80000180, 0);
        e_mis = 1'b0;
        idle(32'h80000184, 0);
`else
        step(0, 0, 1, 32'h00400002, 0, 32'h0, 0, 0, 0, 32'h00400002, 0);
        idle(32'h00400006, 0);
`endif
        // stall suppresses pop; reset clears RAS and EPC
        rst_step();
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h00400004, 1);
        step(0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h00400004, 1);
        rst_step();
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h00400004, 0);
        @(negedge clk);
        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
